pc_unit: RTL
============

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter ADDR_W, default 16, program-counter width in bits; SHALL be a multiple of 8, range 16..32.
REQ-002 Parameter RESET_PC, default 16'hFFFC zero-extended to ADDR_W, PC value loaded on reset.
REQ-003 ph0  input  1  clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 op_valid  input  1  op is presented this cycle.
REQ-006 op  input  3  operation: HOLD, INC, LOAD_L, LOAD_H, LOAD_HL, BRANCH.
REQ-007 adl_in  input  8  new low byte for LOAD_L / LOAD_HL.
REQ-008 adh_in  input  ADDR_W-8  new high part for LOAD_H / LOAD_HL.
REQ-009 offset  input  8  signed two's-complement branch displacement.
REQ-010 pc  output  ADDR_W  current program counter, {pch, pcl}.
REQ-011 busy  output  1  high while a page-cross fixup cycle is pending.
REQ-012 page_cross  output  1  one-cycle pulse in the cycle the fixup completes.

Function
REQ-013 Op SHALL be accepted on a rising edge only when op_valid=1 and busy=0; otherwise PC SHALL hold.
REQ-014 HOLD: PC unchanged.
REQ-015 INC: PC SHALL become PC+1 modulo 2^ADDR_W; carry SHALL propagate from pcl into pch in the same cycle, so all-ones wraps to 0.
REQ-016 LOAD_L: pcl <= adl_in, pch unchanged; LOAD_H: pch <= adh_in, pcl unchanged; LOAD_HL: both loaded in one cycle.
REQ-017 BRANCH: pcl <= (pcl + offset) mod 256 in the accept cycle; pch unchanged in that cycle.
REQ-018 Page cross is defined as: offset>=0 with carry out of the 8-bit add, or offset<0 with no carry out (borrow).
REQ-019 With no page cross, BRANCH SHALL complete in one cycle; busy stays 0; page_cross stays 0.
REQ-020 FSM states: IDLE, FIXUP. IDLE->FIXUP on an accepted BRANCH with page cross; FIXUP->IDLE unconditionally after one cycle.
REQ-021 In FIXUP: busy=1; on the next edge pch <= pch+1 (forward) or pch-1 (backward) modulo 2^(ADDR_W-8); page_cross=1 for the cycle following that edge.
REQ-022 During FIXUP, pc SHALL show {old pch, new pcl}; this intermediate value is architecturally visible.
REQ-023 op_valid asserted during FIXUP SHALL be ignored (not queued); the producer re-presents the op after busy falls.
REQ-024 page_cross and busy SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-025 While reset=1: pc=RESET_PC, state=IDLE, busy=0, page_cross=0, independent of ph0.
REQ-026 Reset asserted during FIXUP SHALL abort the fixup; no pch adjust SHALL occur after reset release.
REQ-027 The first op SHALL be accepted on the first rising ph0 edge after reset deasserts.

Structure
REQ-028 pc_op_t (op encoding) and pc_state_t (IDLE/FIXUP) SHALL live in shared package k6502_pkg, for reuse by the control decoder.
REQ-029 One sub-module, pc_byte_adder: 8-bit pcl add with signed offset, returning sum and page-cross flag; the pch incrementer/decrementer stays inline.
REQ-030 pcl and pch SHALL be a single register set inside pc_unit, replacing the separate low/high select registers.

Verification
REQ-031 Reset, release, INC x3 -> pc 0xFFFC, 0xFFFD, 0xFFFE, 0xFFFF; fourth INC -> 0x0000.
REQ-032 pc=0x12F0, BRANCH offset=0x20 -> cycle 1 pc=0x1210, busy=1; cycle 2 pc=0x1310, page_cross=1, busy=0.
REQ-033 pc=0x1205, BRANCH offset=0xF0 (-16) -> pc=0x12F5 with busy=1, then 0x11F5 with page_cross=1.
REQ-034 pc=0x1240, BRANCH offset=0x10 -> pc=0x1250 in one cycle, busy=0, page_cross=0.
REQ-035 LOAD_HL adh=0xAB adl=0xCD, then INC held valid during a forced FIXUP -> INC ignored while busy=1, accepted once busy=0.
REQ-036 Reset pulsed mid-FIXUP from pc=0x12F0 +0x20 -> pc=0xFFFC, busy=0, no page_cross pulse; repeat with ADDR_W=24.

Source files
------------

// File: rtl/k6502_pkg.sv
// k6502_pkg: definitions shared by the program-counter datapath and the
// control decoder.
//   pc_op_t    : 3-bit PC operation encoding, as driven on pc_unit.op
//   pc_state_t : PC sequencer state (idle, or a pending high-byte fixup)
package k6502_pkg;

    typedef enum logic [2:0] {
        OP_HOLD    = 3'd0,
        OP_INC     = 3'd1,
        OP_LOAD_L  = 3'd2,
        OP_LOAD_H  = 3'd3,
        OP_LOAD_HL = 3'd4,
        OP_BRANCH  = 3'd5
    } pc_op_t;

    typedef logic [0:0] pc_state_t;

    localparam pc_state_t ST_IDLE  = 1'b0;
    localparam pc_state_t ST_FIXUP = 1'b1;

endpackage

// File: rtl/pc_byte_adder.sv
// pc_byte_adder: adds a signed 8-bit branch displacement to the PC low byte.
//   a_i     : current pcl
//   off_i   : two's-complement displacement
//   sum_o   : (a_i + off_i) mod 256
//   cross_o : the branch target lies on a different page
module pc_byte_adder (
    input  logic [7:0] a_i,
    input  logic [7:0] off_i,
    output logic [7:0] sum_o,
    output logic       cross_o
);

    logic [8:0] raw;

    assign raw   = {1'b0, a_i} + {1'b0, off_i};
    assign sum_o = raw[7:0];

    // Forward displacements cross on carry-out.  Backward ones are added as
    // their unsigned 8-bit image, so a missing carry means a borrow occurred.
    assign cross_o = off_i[7] ? ~raw[8] : raw[8];

endmodule

// File: rtl/pc_unit.sv
// pc_unit: program counter with byte-wise loads and relative branches.
// A branch that leaves the current page takes one extra cycle, during which
// the high byte is adjusted.
//   ph0        : clock
//   reset      : asynchronous active-high reset
//   op_valid   : op is presented this cycle
//   op         : operation (pc_op_t)
//   adl_in     : new low byte (LOAD_L / LOAD_HL)
//   adh_in     : new high part (LOAD_H / LOAD_HL)
//   offset     : signed branch displacement
//   pc         : {pch, pcl}
//   busy       : a page-cross fixup is pending; ops are dropped
//   page_cross : one-cycle pulse after the fixup edge
module pc_unit
    import k6502_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(16'hFFFC)
) (
    input  logic              ph0,
    input  logic              reset,
    input  logic              op_valid,
    input  logic [2:0]        op,
    input  logic [7:0]        adl_in,
    input  logic [ADDR_W-9:0] adh_in,
    input  logic [7:0]        offset,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              page_cross
);

    localparam int HW = ADDR_W - 8;

    logic [7:0]    pcl_q, pcl_d;
    logic [HW-1:0] pch_q, pch_d;
    pc_state_t     state_q, state_d;
    logic          dir_q, dir_d;       // 1: fixup increments pch, 0: decrements
    logic          pcx_q, pcx_d;
    logic [7:0]    br_sum;
    logic          br_cross;

    pc_byte_adder u_adder (
        .a_i    (pcl_q),
        .off_i  (offset),
        .sum_o  (br_sum),
        .cross_o(br_cross)
    );

    always_comb begin
        pcl_d   = pcl_q;
        pch_d   = pch_q;
        state_d = state_q;
        dir_d   = dir_q;
        pcx_d   = 1'b0;
        if (state_q == ST_FIXUP) begin
            // Any op presented now is dropped, not queued.
            pch_d   = dir_q ? pch_q + HW'(1) : pch_q - HW'(1);
            state_d = ST_IDLE;
            pcx_d   = 1'b1;
        end else if (op_valid) begin
            case (pc_op_t'(op))
                OP_INC:     {pch_d, pcl_d} = {pch_q, pcl_q} + ADDR_W'(1);
                OP_LOAD_L:  pcl_d = adl_in;
                OP_LOAD_H:  pch_d = adh_in;
                OP_LOAD_HL: begin
                    pcl_d = adl_in;
                    pch_d = adh_in;
                end
                OP_BRANCH: begin
                    pcl_d = br_sum;
                    if (br_cross) begin
                        state_d = ST_FIXUP;
                        dir_d   = ~offset[7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ph0 or posedge reset) begin
        if (reset) begin
            pcl_q   <= RESET_PC[7:0];
            pch_q   <= RESET_PC[ADDR_W-1:8];
            state_q <= ST_IDLE;
            dir_q   <= 1'b0;
            pcx_q   <= 1'b0;
        end else begin
            pcl_q   <= pcl_d;
            pch_q   <= pch_d;
            state_q <= state_d;
            dir_q   <= dir_d;
            pcx_q   <= pcx_d;
        end
    end

    assign pc         = {pch_q, pcl_q};
    assign busy       = (state_q == ST_FIXUP);
    assign page_cross = pcx_q;

endmodule
